fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO built on iCE40 block RAM (EBR), successor to the fixed 8-bit FIFO.
//  Generalises data width and depth. Adds almost-full/almost-empty thresholds, a live fill count,
//  protected push/pop with sticky overflow/underflow errors, and an optional first-word-fall-through (FWFT) read mode.
//  Sits between byte/word producers (UART RX, ADC sampler) and consumers (command parser, SPI TX) in the DMM datapath.
// PARAMETERS
//  pDataWidth    8    word width in bits, 1..16
//  pAddrWidth    9    RAM address bits; usable depth = 2**pAddrWidth words (9 -> 512)
//  pAlmostFull   480  oAlmostFull asserted when count >= this value
//  pAlmostEmpty  32   oAlmostEmpty asserted when count <= this value
//  pFwft         0    0 = standard read (data 1 cycle after pop); 1 = first-word-fall-through
// PORTS
//  iClk          in   1             system clock; all logic rising-edge
//  iRst          in   1             reset, synchronous, active-high
//  iWrEn         in   1             push request
//  iWrData       in   pDataWidth    push data
//  oWrFull       out  1             FIFO full; push ignored
//  oAlmostFull   out  1             count >= pAlmostFull
//  iRdEn         in   1             pop request
//  oRdData       out  pDataWidth    read data
//  oRdValid      out  1             oRdData holds a valid word (see modes)
//  oRdEmpty      out  1             no word available to pop
//  oAlmostEmpty  out  1             count <= pAlmostEmpty
//  oCount        out  pAddrWidth+1  words held, 0..2**pAddrWidth
//  oOverflow     out  1             sticky: push attempted while full
//  oUnderflow    out  1             sticky: pop attempted while empty
// BEHAVIOUR
//  Reset: pointers=0, count=0. Outputs oRdData=0, oRdValid=0, oRdEmpty=1, oWrFull=0,
//   oAlmostEmpty=1, oAlmostFull=0, oOverflow=0, oUnderflow=0. A pending push/pop in the reset cycle is discarded.
//   Reset is the only clear for the sticky errors.
//  Accept rules, evaluated on state before the edge:
//   - push accepted = iWrEn & !oWrFull
//   - pop accepted = iRdEn & !oRdEmpty
//   - Push while full is dropped; it does NOT succeed even if a pop occurs in the same cycle.
//     No same-address read/write can occur.
//   - Pop while empty is dropped, even if a push occurs in the same cycle.
//  Pointers: wr/rd pointers are pAddrWidth bits and wrap naturally 2**pAddrWidth-1 -> 0.
//  Count update:
//   - +1 on push only, -1 on pop only, unchanged on both or neither.
//   - Never exceeds 2**pAddrWidth and never goes below 0.
//  Flags: all flags are decoded from registered count/state only. No combinational input->output path.
//   - oWrFull = (count == 2**pAddrWidth)
//   - oRdEmpty (pFwft=0) = (count == 0)
//  pFwft=0:
//   - An accepted pop at edge N drives oRdData valid after edge N+1, with oRdValid=1 for exactly that cycle.
//   - oRdData holds its value until the next accepted pop.
//   - A word pushed at edge N is poppable from cycle N+1 (count visible).
//  pFwft=1:
//   - One output register plus valid bit sits ahead of the RAM. oRdValid = !oRdEmpty.
//   - oRdData shows the head word before iRdEn; a pop at edge N advances to the next word.
//   - Refill: the RAM read is issued whenever the output register is empty, or being popped, and RAM holds data.
//   - A word pushed into an empty FIFO at edge N appears with oRdValid=1 after edge N+2.
//   - Back-to-back pops sustain 1 word/cycle while RAM is non-empty.
//   - oCount includes the word in the output register.
//  Errors: oOverflow/oUnderflow set on the edge following the offending request and stay high until iRst.
//  Parameters are checked at elaboration: the build fails unless pAlmostEmpty < pAlmostFull <= 2**pAddrWidth.
// TESTING
//  1. Reset, push 0x01..0x05 one per cycle, then pop 5 (pFwft=0) -> oRdData 0x01..0x05 in order, each 1 cycle after pop; oCount 5->0; oRdEmpty=1.
//  2. Fill 512 words -> oWrFull=1 and oCount=512. Push 0xAA -> dropped, oOverflow=1. Drain all 512 -> data matches, 0xAA absent, and pointers wrap to 0 cleanly.
//  3. Empty FIFO with iWrEn=iRdEn=1 (0x3C) -> pop rejected, oUnderflow=1, oCount=1. Next pop returns 0x3C.
//  4. Count=100 with push+pop every cycle for 600 cycles -> oCount stays 100 and data is FIFO-ordered across the wrap.
//  5. pFwft=1: push 0x11 into empty FIFO at edge N -> oRdValid=1, oRdData=0x11 after N+2. Push 0x22,0x33, then pop 3 consecutive cycles -> 0x11,0x22,0x33 with no bubble.
//  6. Thresholds: cross 32/33 and 479/480 in both directions -> oAlmostEmpty/oAlmostFull toggle exactly there. Assert iRst mid-burst -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parameterised single-clock FIFO on block RAM: fill count, almost-full/empty thresholds,
// sticky overflow/underflow, and an optional first-word-fall-through read port.
module fifo_sync_param #(
    parameter int pDataWidth   = 8,
    parameter int pAddrWidth   = 9,
    parameter int pAlmostFull  = 480,
    parameter int pAlmostEmpty = 32,
    parameter int pFwft        = 0
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iWrEn,
    input  logic [pDataWidth-1:0] iWrData,
    output logic                  oWrFull,
    output logic                  oAlmostFull,
    input  logic                  iRdEn,
    output logic [pDataWidth-1:0] oRdData,
    output logic                  oRdValid,
    output logic                  oRdEmpty,
    output logic                  oAlmostEmpty,
    output logic [pAddrWidth:0]   oCount,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam int                  Depth        = 1 << pAddrWidth;
    localparam logic [pAddrWidth:0] DepthC       = {1'b1, {pAddrWidth{1'b0}}};
    localparam logic [pAddrWidth:0] AlmostFullC  = pAlmostFull[pAddrWidth:0];
    localparam logic [pAddrWidth:0] AlmostEmptyC = pAlmostEmpty[pAddrWidth:0];

    generate
        if (!(pAlmostEmpty >= 0 && pAlmostEmpty < pAlmostFull && pAlmostFull <= Depth &&
              pDataWidth >= 1 && pDataWidth <= 16 && pAddrWidth >= 1)) begin : gBadParams
            $error("fifo_sync_param: need pAlmostEmpty < pAlmostFull <= 2**pAddrWidth, 1 <= pDataWidth <= 16");
        end
    endgenerate

    logic [pDataWidth-1:0] mem [0:Depth-1];
    logic [pDataWidth-1:0] ramQ;
    logic [pAddrWidth-1:0] wrPtr, rdPtr;
    logic [pAddrWidth:0]   count;
    logic                  full, empty, push, pop, rdIssue;

    // Accept decisions only look at registered state, so a pop can never free room
    // for a push in the same cycle and the RAM never sees a same-address read/write.
    assign full = (count == DepthC);
    assign push = iWrEn & ~full;
    assign pop  = iRdEn & ~empty;

    assign oWrFull      = full;
    assign oCount       = count;
    assign oAlmostFull  = (count >= AlmostFullC);
    assign oAlmostEmpty = (count <= AlmostEmptyC);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            oOverflow  <= 1'b0;
            oUnderflow <= 1'b0;
        end else begin
            if (push)    wrPtr <= wrPtr + 1'b1;
            if (rdIssue) rdPtr <= rdPtr + 1'b1;
            if (push & ~pop)      count <= count + 1'b1;
            else if (pop & ~push) count <= count - 1'b1;
            if (iWrEn & full)  oOverflow  <= 1'b1;
            if (iRdEn & empty) oUnderflow <= 1'b1;
        end
    end

    // Plain EBR: synchronous write, registered read, no reset on the array.
    always_ff @(posedge iClk) begin
        if (push)    mem[wrPtr] <= iWrData;
        if (rdIssue) ramQ <= mem[rdPtr];
    end

    generate
        if (pFwft == 0) begin : gStd
            logic rdPend;

            assign empty    = (count == '0);
            assign rdIssue  = pop;
            assign oRdEmpty = empty;

            always_ff @(posedge iClk) begin
                if (iRst) begin
                    rdPend   <= 1'b0;
                    oRdValid <= 1'b0;
                    oRdData  <= '0;
                end else begin
                    rdPend   <= pop;
                    oRdValid <= rdPend;
                    if (rdPend) oRdData <= ramQ;
                end
            end
        end else begin : gFwft
            // ramQ acts as a prefetch stage in front of the output register; keeping
            // both full lets back-to-back pops run at one word per cycle.
            logic [pAddrWidth:0] ramCnt;
            logic                stageValid, outValid, load;

            assign empty    = ~outValid;
            assign load     = stageValid & (~outValid | pop);
            assign rdIssue  = (ramCnt != '0) & (~stageValid | load);
            assign oRdEmpty = ~outValid;
            assign oRdValid = outValid;

            always_ff @(posedge iClk) begin
                if (iRst) begin
                    ramCnt     <= '0;
                    stageValid <= 1'b0;
                    outValid   <= 1'b0;
                    oRdData    <= '0;
                end else begin
                    case ({push, rdIssue})
                        2'b10:   ramCnt <= ramCnt + 1'b1;
                        2'b01:   ramCnt <= ramCnt - 1'b1;
                        default: ramCnt <= ramCnt;
                    endcase
                    if (rdIssue)   stageValid <= 1'b1;
                    else if (load) stageValid <= 1'b0;
                    if (load) begin
                        outValid <= 1'b1;
                        oRdData  <= ramQ;
                    end else if (pop) begin
                        outValid <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule
